// File: rtl/svc_soc_lifecycle_pkg.sv
// Shared types and constants for the SoC run-lifecycle controller.
// Optional feature macro: SVC_LIFECYCLE_PROGRESS_EN (see svc_soc_lifecycle.sv).
package svc_soc_lifecycle_pkg;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        R_NONE    = 3'd0,
        R_EXIT    = 3'd1,
        R_EBREAK  = 3'd2,
        R_TRAP    = 3'd3,
        R_TIMEOUT = 3'd4
    } reason_t;

    localparam logic [31:0] EXIT_TRAP    = 32'hFFFF_FFFF;
    localparam logic [31:0] EXIT_TIMEOUT = 32'hFFFF_FFFE;

    // A run passes on a clean exit(0) or on an ebreak.
    function automatic logic lc_verdict(reason_t r, logic [31:0] code);
        return ((r == R_EXIT) && (code == 32'd0)) || (r == R_EBREAK);
    endfunction

endpackage

// File: rtl/svc_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used for the run-cycle, retired-instruction and watchdog counts.
module svc_sat_counter
    import svc_soc_lifecycle_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, hold at all-ones, or step by one.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/svc_soc_lifecycle.sv
// Run-lifecycle controller: CPU reset hold, termination watch, UART drain, verdict.
// SVC_LIFECYCLE_PROGRESS_EN: watchdog clears on retire (hang detection) instead of capping run length.
module svc_soc_lifecycle
    import svc_soc_lifecycle_pkg::*;
#(
    parameter int          RESET_CYCLES    = 16,
    parameter int          WATCHDOG_CYCLES = 1_000_000,
    parameter int          DRAIN_MAX       = 100_000,
    parameter logic [31:0] EXIT_ADDR       = 32'hFFFF_FFF0,
    parameter int          CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             cpu_rst_n,
    output logic             cpu_halt,
    input  logic             retire,
    input  logic             ebreak,
    input  logic             trap,
    input  logic             dbus_wen,
    input  logic [31:0]      dbus_addr,
    input  logic [31:0]      dbus_wdata,
    input  logic             uart_busy,
    output logic             done,
    output logic             pass,
    output logic [2:0]       reason,
    output logic [31:0]      exit_code,
    output logic             drain_to,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instret
);

    localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int DRAIN_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0]   WDOG_LAST  = CNT_W'(WATCHDOG_CYCLES - 1);

    state_t               state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    reason_t              reason_q, reason_d;
    logic [31:0]          exit_code_q, exit_code_d;
    logic                 drain_to_q, drain_to_d;
    logic                 cpu_rst_n_q;
    logic                 cpu_halt_q;
    logic                 done_q;
    logic                 pass_q;

    logic [CNT_W-1:0]     cycles_q;
    logic [CNT_W-1:0]     instret_q;
    logic [CNT_W-1:0]     wdog_q;

    logic                 run_active;
    logic                 exit_hit;
    logic                 wdog_hit;

    assign run_active = (state_q == RUN);
    assign exit_hit   = dbus_wen && (dbus_addr == EXIT_ADDR);
    assign wdog_hit   = (wdog_q == WDOG_LAST);

    svc_sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (run_active),
        .clr_i (1'b0),
        .cnt_o (cycles_q)
    );

    svc_sat_counter #(.W(CNT_W)) u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (run_active && retire),
        .clr_i (1'b0),
        .cnt_o (instret_q)
    );

`ifdef SVC_LIFECYCLE_PROGRESS_EN
    svc_sat_counter #(.W(CNT_W)) u_wdog (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (run_active),
        .clr_i (run_active && retire),
        .cnt_o (wdog_q)
    );
`else
    assign wdog_q = cycles_q;
`endif

    // Lifecycle sequencing and termination latching.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        drain_d     = drain_q;
        reason_d    = reason_q;
        exit_code_d = exit_code_q;
        drain_to_d  = drain_to_q;
        unique case (state_q)
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RUN: begin
                if (exit_hit) begin
                    state_d     = DRAIN;
                    reason_d    = R_EXIT;
                    exit_code_d = dbus_wdata;
                end else if (ebreak) begin
                    state_d     = DRAIN;
                    reason_d    = R_EBREAK;
                    exit_code_d = 32'd0;
                end else if (trap) begin
                    state_d     = DRAIN;
                    reason_d    = R_TRAP;
                    exit_code_d = EXIT_TRAP;
                end else if (wdog_hit) begin
                    state_d     = DRAIN;
                    reason_d    = R_TIMEOUT;
                    exit_code_d = EXIT_TIMEOUT;
                end
            end
            DRAIN: begin
                if (!uart_busy) begin
                    state_d = DONE;
                end else if (drain_q == DRAIN_LAST) begin
                    state_d    = DONE;
                    drain_to_d = 1'b1;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // FSM and latched-result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            hold_q      <= '0;
            drain_q     <= '0;
            reason_q    <= R_NONE;
            exit_code_q <= '0;
            drain_to_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            drain_q     <= drain_d;
            reason_q    <= reason_d;
            exit_code_q <= exit_code_d;
            drain_to_q  <= drain_to_d;
        end
    end

    // Control outputs decoded from next state so they are pure flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rst_n_q <= 1'b0;
            cpu_halt_q  <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            cpu_rst_n_q <= (state_d != HOLD);
            cpu_halt_q  <= (state_d == DRAIN) || (state_d == DONE);
            done_q      <= (state_d == DONE);
            pass_q      <= (state_d == DONE) && lc_verdict(reason_d, exit_code_d);
        end
    end

    assign cpu_rst_n = cpu_rst_n_q;
    assign cpu_halt  = cpu_halt_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign reason    = reason_q;
    assign exit_code = exit_code_q;
    assign drain_to  = drain_to_q;
    assign cycles    = cycles_q;
    assign instret   = instret_q;

endmodule

// File: doc/svc_soc_lifecycle.md
Name: svc_soc_lifecycle

Overview:
- Run-lifecycle controller for the RISC-V SoC simulation and FPGA harness.
- Holds the CPU in reset after power-up, then releases it and watches for a termination event: exit-register write, ebreak, trap, or watchdog expiry.
- After termination, stalls the CPU, lets the UART drain, then latches a final verdict.
- Sits between the top-level reset and the CPU/peripheral bus. Sim wrappers and board tops read `done`, `pass` and `exit_code` from it.

Parameters:
- `RESET_CYCLES`, 16: cycles `cpu_rst_n` is held low after `rst_n` deasserts. Must be ≥1.
- `WATCHDOG_CYCLES`, 1_000_000: RUN cycles allowed before TIMEOUT. Must be ≥1.
- `DRAIN_MAX`, 100_000: maximum cycles spent waiting for `uart_busy` to clear.
- `EXIT_ADDR`, 32'hFFFF_FFF0: word address of the exit register on the data bus.
- `CNT_W`, 32: width of the `cycles` and `instret` counters.

Ports:
- `clk` input 1: sole clock.
- `rst_n` input 1: asynchronous active-low reset.
- `cpu_rst_n` output 1: active-low reset to the CPU.
- `cpu_halt` output 1: stall request to the CPU.
- `retire` input 1: one instruction retired this cycle.
- `ebreak` input 1: ebreak retired this cycle.
- `trap` input 1: illegal instruction or misaligned access this cycle.
- `dbus_wen` input 1: data-bus write strobe.
- `dbus_addr` input 32: data-bus write address.
- `dbus_wdata` input 32: data-bus write data.
- `uart_busy` input 1: UART TX FIFO non-empty or shifting.
- `done` output 1: run finished, verdict valid.
- `pass` output 1: verdict.
- `reason` output 3: 0 NONE, 1 EXIT, 2 EBREAK, 3 TRAP, 4 TIMEOUT.
- `exit_code` output 32: latched exit value.
- `drain_to` output 1: drain ended by `DRAIN_MAX`, not by UART idle.
- `cycles` output `CNT_W`: RUN cycles elapsed.
- `instret` output `CNT_W`: retired instructions.

Behaviour:
- Reset is asynchronous and active-low on `rst_n` (fixed); single clock `clk`.
- Reset values:
  - state = HOLD.
  - `cpu_rst_n` = 0, `cpu_halt` = 0.
  - `done`, `pass`, `drain_to` = 0.
  - `reason` = 0, `exit_code` = 0.
  - `cycles`, `instret`, and all internal counters = 0.
- Reset asserted in any state aborts immediately to these values. This applies mid-run and mid-drain.
- HOLD:
  - Count up to `RESET_CYCLES`.
  - On the cycle the count reaches `RESET_CYCLES`-1, go to RUN.
  - `cpu_rst_n` rises on the first RUN cycle, from a register, so no combinational path from state.
- RUN:
  - `cycles` increments every cycle.
  - `instret` increments on `retire`.
  - Both counters saturate at all-ones and never wrap.
  - Termination is checked each cycle. Priority when events coincide:
    1. EXIT: `dbus_wen` && `dbus_addr` == `EXIT_ADDR`. Sets `exit_code` = `dbus_wdata`.
    2. EBREAK: `exit_code` = 0.
    3. TRAP: `exit_code` = 32'hFFFF_FFFF.
    4. TIMEOUT: the watchdog counter reaches `WATCHDOG_CYCLES`-1. `exit_code` = 32'hFFFF_FFFE.
  - On termination, latch `reason` and `exit_code`, then go to DRAIN next cycle.
  - A retire in the terminating cycle still counts toward `instret`.
- DRAIN:
  - `cpu_halt` = 1; `cpu_rst_n` stays 1.
  - `cycles` and `instret` are frozen.
  - Go to DONE on the first cycle `uart_busy` == 0.
  - Otherwise go to DONE after `DRAIN_MAX` cycles and set `drain_to` = 1.
  - If `uart_busy` is already 0 on DRAIN entry, DRAIN lasts exactly 1 cycle.
- DONE:
  - Terminal state: `done` = 1, `cpu_halt` = 1.
  - `pass` = (`reason` == EXIT && `exit_code` == 0) || `reason` == EBREAK.
  - Exits only via `rst_n`.
  - Further bus writes, ebreak or trap inputs are ignored.
- `reason`, `exit_code` and `pass` are stable from the cycle `done` rises. Latched `reason` and `exit_code` are not modified after RUN.
- All outputs are registered.

Optional Feature:
- Macro: `SVC_LIFECYCLE_PROGRESS_EN`.
- Defined: the watchdog counter clears on every `retire`, so TIMEOUT means `WATCHDOG_CYCLES` consecutive cycles with no retirement (hang detection).
- Undefined: the watchdog counter equals `cycles`, an absolute run-length cap. The counter is not instantiated separately.
- Neither setting changes `cycles` or `instret`.

Decomposition:
- Package `svc_soc_lifecycle_pkg` holds:
  - `state_t` enum: HOLD, RUN, DRAIN, DONE.
  - `reason_t` 3-bit enum.
  - Exit-code constants `EXIT_TRAP` and `EXIT_TIMEOUT`.
- One sub-module: `svc_sat_counter`, a parameterised saturating counter with `inc` and `clr`, instantiated for `cycles`, `instret` and the watchdog.
- The FSM and latching stay in the top module.

Test Plan:
- Release and exit:
  - `RESET_CYCLES`=4; write 0 to `EXIT_ADDR` at RUN cycle 10, `uart_busy`=0.
  - `cpu_rst_n` high from cycle 4.
  - `done` 2 cycles after the write.
  - `reason`=1, `pass`=1, `cycles`=11.
- Simultaneous events: exit write of 5, `ebreak` and `trap` in the same cycle → `reason`=1, `exit_code`=5, `pass`=0.
- Absolute watchdog (macro off), `WATCHDOG_CYCLES`=50:
  - Continuous `retire` → `reason`=4, `exit_code`=32'hFFFF_FFFE, `instret`=50.
- Progress watchdog (macro on), `WATCHDOG_CYCLES`=50:
  - `retire` every 10 cycles for 500 cycles → no timeout.
  - Then stop retiring → TIMEOUT exactly 50 cycles after the last retire.
- Drain paths:
  - ebreak with `uart_busy` high for 20 cycles, `DRAIN_MAX`=100 → `done` at DRAIN+20, `drain_to`=0.
  - `uart_busy` stuck high → `done` after 100 cycles, `drain_to`=1, `pass`=1.
- Reset mid-drain: assert `rst_n` low during DRAIN → all outputs return to reset values asynchronously; the next run completes normally.
